// File: rtl/bcd_to_unsigned.sv
// -----------------------------------------------------------------------------
// bcd_to_unsigned
//
// Purpose:
//   Iterative reverse double-dabble converter. It accepts a packed BCD number
//   and returns its unsigned binary value. The converter performs one shift per
//   clock. This block is the inverse of unsigned_to_bcd and uses the same
//   trigger/idle handshake.
//
// Handshake (valid/ready style):
//   - idle acts as "ready". trigger acts as "valid".
//   - A request is accepted on a rising edge where idle=1 and trigger=1.
//   - bcd is captured on that same edge.
//   - trigger is ignored while idle=0. Such a trigger is not queued and does not
//     restart the running conversion.
//   - done pulses for one cycle. out and error update on the same edge.
//   - Latency from acceptance to done is W+1 cycles.
//   - Holding trigger high gives a new conversion every W+2 cycles.
//
// Parameters:
//   N_DIGITS : number of BCD digits at the input. The result width is
//              W = 4*N_DIGITS, which always holds 10^N_DIGITS-1.
//
// Ports:
//   clk     : system clock. All state updates on the rising edge.
//   reset   : asynchronous, active-high reset. Abandons any conversion.
//   trigger : start request. Sampled only while idle=1.
//   bcd     : packed BCD input. Digit 0 is in bits [3:0].
//   idle    : 1 = ready to accept trigger. 0 = conversion in progress.
//   done    : one-cycle completion pulse.
//   error   : invalid-digit flag for the last conversion.
//             This flag is always 0 unless the check is enabled.
//   out     : binary result. Holds its value until the next done.
//
// Optional feature (macro BCD_TO_UNSIGNED_DIGIT_CHECK_EN):
//   - When the macro is defined, any captured digit above 9 sets an invalid
//     flag.
//   - At completion, that flag drives error and forces out to 0.
//   - When the macro is not defined, no check logic is built and error is
//     tied to 0.
//
// The FSM state is the enum variable 'state'. It is kept named and
// unflattened so that checkers can bind to it.
// -----------------------------------------------------------------------------
module bcd_to_unsigned #(
  parameter int N_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [4*N_DIGITS-1:0] bcd,
  output logic                  idle,
  output logic                  done,
  output logic                  error,
  output logic [4*N_DIGITS-1:0] out
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [W-1:0]  bcd_reg;
  logic [W-1:0]  bin_reg;
  logic [CW-1:0] cnt;

  logic [W-1:0]  bcd_shift;
  logic [W-1:0]  bin_shift;

  assign idle = (state == S_IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (trigger) state_next = S_SHIFT;
      S_SHIFT: if (cnt == CNT_LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One reverse double-dabble step.
  // Shift {bcd_reg, bin_reg} right by one bit. Then correct every shifted
  // digit that reached 8 or more by subtracting 3. A digit's MSB being set is
  // exactly the ">= 8" test.
  always_comb begin
    bcd_shift = {1'b0, bcd_reg[W-1:1]};
    bin_shift = {bcd_reg[0], bin_reg[W-1:1]};
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_shift[4*i+3]) begin
        bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
  logic invalid;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`else
  assign error = 1'b0;
`endif

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      out     <= '0;
      done    <= 1'b0;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
      invalid <= 1'b0;
      error   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            bcd_reg <= bcd;
            bin_reg <= '0;
            cnt     <= '0;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
            invalid <= has_bad_digit(bcd);
`endif
          end
        end
        S_SHIFT: begin
          bcd_reg <= bcd_shift;
          bin_reg <= bin_shift;
          cnt     <= cnt + CW'(1);
        end
        S_DONE: begin
          done <= 1'b1;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
          error <= invalid;
          out   <= invalid ? '0 : bin_reg;
`else
          out   <= bin_reg;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_unsigned
//
// Self-checking bench for bcd_to_unsigned with N_DIGITS=8.
//   - When a request is driven, the expected result, error flag and done cycle
//     are pushed to queues.
//   - A negedge monitor pops these queues on every done pulse and compares.
//   - Expected values come from a decimal digit-weight model.
// -----------------------------------------------------------------------------
module tb_bcd_to_unsigned;

  localparam int N_DIGITS = 8;
  localparam int W        = 4 * N_DIGITS;
  localparam int LAT      = W + 1;

  logic         clk;
  logic         reset;
  logic         trigger;
  logic [W-1:0] bcd;
  logic         idle;
  logic         done;
  logic         error;
  logic [W-1:0] out;

  int checks;
  int fails;
  int cyc;
  logic prev_done;

  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  int           cyc_q[$];

  bcd_to_unsigned #(.N_DIGITS(N_DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd     (bcd),
    .idle    (idle),
    .done    (done),
    .error   (error),
    .out     (out)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: weighted sum of decimal digits.
  // Invalid digits are flagged separately.
  function automatic logic [W-1:0] model_value(input logic [W-1:0] v);
    logic [63:0] acc;
    logic [63:0] weight;
    acc    = 64'd0;
    weight = 64'd1;
    for (int i = 0; i < N_DIGITS; i++) begin
      acc    = acc + weight * 64'(v[4*i +: 4]);
      weight = weight * 64'd10;
    end
    return acc[W-1:0];
  endfunction

  function automatic logic model_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Push the expected result for a capture on the coming posedge.
  // This is called at a negedge.
  task automatic push_exp(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
    bad = model_bad(v);
`endif
    exp_q.push_back(bad ? '0 : model_value(v));
    err_q.push_back(bad);
    cyc_q.push_back(cyc + 1 + LAT);
  endtask

  // Driver: single-cycle trigger pulse
  task automatic convert(input logic [W-1:0] v);
    @(negedge clk);
    check_bit("idle_before_trigger", idle, 1'b1);
    bcd     = v;
    trigger = 1'b1;
    push_exp(v);
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // Wait until the scoreboard drains. The wait is bounded.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s_timeout: observed %0d pending expected 0 pending", tag, exp_q.size());
    end
  endtask

  // Scoreboard monitor
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_done: observed done=1 at cycle %0d expected no done", cyc);
      end
      if (exp_q.size() != 0) begin
        logic [W-1:0] e_out;
        logic         e_err;
        int           e_cyc;
        e_out = exp_q.pop_front();
        e_err = err_q.pop_front();
        e_cyc = cyc_q.pop_front();
        check_word("result", out, e_out);
        check_bit("error_flag", error, e_err);
        checks++;
        assert (cyc == e_cyc) else begin
          fails++;
          $error("FAIL done_cycle: observed %0d expected %0d", cyc, e_cyc);
        end
      end
      checks++;
      assert (!prev_done) else begin
        fails++;
        $error("FAIL done_width: observed done high 2 cycles expected 1 cycle");
      end
    end
    prev_done = done;
  end

  // Directed stimulus
  initial begin
    reset   = 1'b1;
    trigger = 1'b0;
    bcd     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state held with no trigger
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_bit("rst_idle", idle, 1'b1);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_error", error, 1'b0);
      check_word("rst_out", out, '0);
    end

    // Basic conversions and boundaries
    convert(32'h1234_5678);
    drain("basic");
    check_word("basic_hold", out, 32'h00BC_614E);
    convert(32'h9999_9999);
    drain("all_nines");
    check_word("nines_hold", out, 32'h05F5_E0FF);
    convert(32'h0000_0000);
    drain("all_zero");

    // Random valid BCD values
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] v;
      for (int d = 0; d < N_DIGITS; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      convert(v);
      drain("random");
    end

    // Back-to-back with trigger held.
    // bcd is flipped right after each capture to show it is ignored.
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      bcd     = (n % 2) ? 32'h0000_1000 : 32'h0000_0042;
      trigger = 1'b1;
      push_exp(bcd);
      @(negedge clk);
      bcd = (n % 2) ? 32'h0000_0042 : 32'h0000_1000;
      if (n == 3) trigger = 1'b0;
      if (n < 3) repeat (33) @(negedge clk);
    end
    drain("back_to_back");
    check_word("b2b_last", out, 32'h0000_03E8);

    // A trigger and bcd change mid-conversion are ignored
    convert(32'h0031_4159);
    repeat (9) @(negedge clk);
    bcd     = 32'h0000_0777;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    drain("ignore_mid");
    check_bit("ignore_idle", idle, 1'b1);

    // Reset in mid-conversion is asynchronous and produces no done
    convert(32'h0000_2468);
    repeat (19) @(negedge clk);
    check_bit("busy_before_reset", idle, 1'b0);
    reset = 1'b1;
    #1;
    check_bit("async_rst_idle", idle, 1'b1);
    check_word("async_rst_out", out, '0);
    check_bit("async_rst_done", done, 1'b0);
    exp_q.delete();
    err_q.delete();
    cyc_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_word("post_rst_out", out, '0);
    convert(32'h0000_2468);
    drain("after_reset");

`ifdef BCD_TO_UNSIGNED_DIGIT_CHECK_EN
    convert(32'h0000_001A);
    drain("bad_digit");
    check_bit("bad_error_hold", error, 1'b1);
    convert(32'h0000_0019);
    drain("good_after_bad");
    check_word("good_after_bad_out", out, 32'h0000_0013);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
